// File: rtl/btc_job_loader_if.sv
// Bus bundle for btc_job_loader: Wishbone classic slave port plus the job valid/ready stream.
// The slave modport is the loader's view; master is the firmware/miner side.
interface btc_job_loader_if #(
  parameter int BITS      = 32,
  parameter int HDR_WORDS = 19
);
  logic                      wbs_cyc_i;
  logic                      wbs_stb_i;
  logic                      wbs_we_i;
  logic [BITS/8-1:0]         wbs_sel_i;
  logic [BITS-1:0]           wbs_adr_i;
  logic [BITS-1:0]           wbs_dat_i;
  logic                      wbs_ack_o;
  logic [BITS-1:0]           wbs_dat_o;
  logic                      job_valid;
  logic                      job_ready;
  logic [BITS*HDR_WORDS-1:0] job_header;
  logic [255:0]              job_target;
  logic [BITS-1:0]           job_nonce_start;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, job_ready,
    output wbs_ack_o, wbs_dat_o, job_valid, job_header, job_target, job_nonce_start
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, job_ready,
    input  wbs_ack_o, wbs_dat_o, job_valid, job_header, job_target, job_nonce_start
  );
endinterface

// File: rtl/btc_job_loader.sv
// Wishbone job staging, commit snapshot and nBits-to-target expansion for the miner controller.
// Define JOB_LOADER_TARGET_DECODE_EN to build the compact-target shifter; otherwise nBits is passed raw.
module btc_job_loader #(
  parameter int BITS      = 32,
  parameter int HDR_WORDS = 19
) (
  input logic             clk,
  input logic             rst_n,
  btc_job_loader_if.slave bus
);
  localparam int         STG_WORDS  = HDR_WORDS + 1;
  localparam int         HDR_W      = BITS * HDR_WORDS;
  localparam logic [4:0] IDX_NONCE  = 5'd19;
  localparam logic [4:0] IDX_CTRL   = 5'd20;
  localparam logic [4:0] IDX_STATUS = 5'd21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_VALID  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [BITS-1:0]   stg_r [STG_WORDS];
  logic              ack_r;
  logic [BITS-1:0]   dat_r;
  logic              job_valid_r;
  logic [HDR_W-1:0]  job_header_r;
  logic [255:0]      job_target_r;
  logic [BITS-1:0]   job_nonce_r;
  logic              target_err_r;
  logic              overrun_r;
  logic [7:0]        jobs_taken_r;

  logic              req_s;
  logic              wr_s;
  logic [4:0]        idx_s;
  logic              ctrl_wr_s;
  logic              commit_s;
  logic              clr_s;
  logic              xfer_s;
  logic              accept_s;
  logic              drop_s;
  logic              decoding_s;
  logic [BITS-1:0]   stg_nbits_s;
  logic [BITS-1:0]   status_s;
  logic [BITS-1:0]   rd_s;
  logic              unused_s;

`ifdef JOB_LOADER_TARGET_DECODE_EN
  logic [7:0]        shift_cnt_r;
  logic              shift_left_r;
  logic [7:0]        exp_s;
  logic              nbits_err_s;
  logic [7:0]        shift_cnt_s;
`endif

  assign req_s       = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_r;
  assign wr_s        = req_s & bus.wbs_we_i;
  assign idx_s       = bus.wbs_adr_i[6:2];
  assign ctrl_wr_s   = wr_s & (idx_s == IDX_CTRL) & bus.wbs_sel_i[0];
  assign commit_s    = ctrl_wr_s & bus.wbs_dat_i[0];
  assign clr_s       = ctrl_wr_s & bus.wbs_dat_i[1];
  assign xfer_s      = job_valid_r & bus.job_ready;
  assign decoding_s  = (state_r == ST_DECODE);
  assign stg_nbits_s = stg_r[HDR_WORDS-1];
  assign status_s    = {16'h0000, jobs_taken_r, 4'h0, overrun_r, target_err_r, decoding_s, job_valid_r};
  assign unused_s    = ^{bus.wbs_adr_i[BITS-1:7], bus.wbs_adr_i[1:0]};

`ifdef JOB_LOADER_TARGET_DECODE_EN
  // Compact exponent: byte shift count relative to the 3-byte mantissa, plus malformed-target detection
  assign exp_s       = stg_nbits_s[31:24];
  assign nbits_err_s = stg_nbits_s[23] | (exp_s > 8'd32);
  assign shift_cnt_s = (exp_s > 8'd3) ? (exp_s - 8'd3) : (8'd3 - exp_s);
`endif

  assign bus.wbs_ack_o       = ack_r;
  assign bus.wbs_dat_o       = dat_r;
  assign bus.job_valid       = job_valid_r;
  assign bus.job_header      = job_header_r;
  assign bus.job_target      = job_target_r;
  assign bus.job_nonce_start = job_nonce_r;

  // Read-data mux for the register map
  always_comb begin
    rd_s = {BITS{1'b0}};
    if (idx_s <= IDX_NONCE) begin
      rd_s = stg_r[idx_s];
    end else if (idx_s == IDX_STATUS) begin
      rd_s = status_s;
    end else begin
      rd_s = {BITS{1'b0}};
    end
  end

  // Wishbone acknowledge, registered read data and byte-lane staging writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
      dat_r <= {BITS{1'b0}};
      for (int w = 0; w < STG_WORDS; w++) begin
        stg_r[w] <= {BITS{1'b0}};
      end
    end else begin
      ack_r <= req_s;
      if (req_s) begin
        dat_r <= rd_s;
      end
      if (wr_s && (idx_s <= IDX_NONCE)) begin
        for (int b = 0; b < BITS/8; b++) begin
          if (bus.wbs_sel_i[b]) begin
            stg_r[idx_s][8*b +: 8] <= bus.wbs_dat_i[8*b +: 8];
          end
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; a commit coinciding with a handshake transfer chains straight into the next job
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (commit_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        drop_s = commit_s;
`ifdef JOB_LOADER_TARGET_DECODE_EN
        if (target_err_r || (shift_cnt_r == 8'd0)) begin
          state_nxt_s = ST_VALID;
        end else begin
          state_nxt_s = ST_DECODE;
        end
`else
        state_nxt_s = ST_VALID;
`endif
      end
      ST_VALID: begin
        if (xfer_s) begin
          if (commit_s) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_DECODE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          drop_s      = commit_s;
          state_nxt_s = ST_VALID;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Job snapshot, target shifter and status bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job_valid_r  <= 1'b0;
      job_header_r <= {HDR_W{1'b0}};
      job_target_r <= 256'd0;
      job_nonce_r  <= {BITS{1'b0}};
      target_err_r <= 1'b0;
      overrun_r    <= 1'b0;
      jobs_taken_r <= 8'd0;
`ifdef JOB_LOADER_TARGET_DECODE_EN
      shift_cnt_r  <= 8'd0;
      shift_left_r <= 1'b0;
`endif
    end else begin
      job_valid_r <= (state_nxt_s == ST_VALID);
      if (xfer_s) begin
        jobs_taken_r <= jobs_taken_r + 8'd1;
      end
      // Clear is applied after the dropped-commit set, so a combined write leaves overrun at 0
      if (clr_s) begin
        overrun_r <= 1'b0;
      end else if (drop_s) begin
        overrun_r <= 1'b1;
      end
      if (accept_s) begin
        for (int i = 0; i < HDR_WORDS; i++) begin
          job_header_r[BITS*i +: BITS] <= stg_r[i];
        end
        job_nonce_r <= stg_r[HDR_WORDS];
`ifdef JOB_LOADER_TARGET_DECODE_EN
        job_target_r <= {233'd0, stg_nbits_s[22:0]};
        target_err_r <= nbits_err_s;
        shift_cnt_r  <= shift_cnt_s;
        shift_left_r <= (exp_s > 8'd3);
`else
        job_target_r <= {{(256-BITS){1'b0}}, stg_nbits_s};
        target_err_r <= 1'b0;
`endif
      end
`ifdef JOB_LOADER_TARGET_DECODE_EN
      else if (state_r == ST_DECODE) begin
        if (target_err_r) begin
          job_target_r <= 256'd0;
        end else if (shift_cnt_r != 8'd0) begin
          shift_cnt_r <= shift_cnt_r - 8'd1;
          if (shift_left_r) begin
            job_target_r <= {job_target_r[247:0], 8'h00};
          end else begin
            job_target_r <= {8'h00, job_target_r[255:8]};
          end
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_btc_job_loader.sv
// Directed self-checking bench for btc_job_loader; expectations follow the
// JOB_LOADER_TARGET_DECODE_EN setting of the build.
module tb_btc_job_loader;
`ifdef JOB_LOADER_TARGET_DECODE_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  btc_job_loader_if bus ();

  btc_job_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wb_write(input logic [4:0] idx, input logic [31:0] data, input logic [3:0] sel);
    bus.wbs_adr_i = {25'd0, idx, 2'b00};
    bus.wbs_dat_i = data;
    bus.wbs_sel_i = sel;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [4:0] idx, output logic [31:0] data);
    bus.wbs_adr_i = {25'd0, idx, 2'b00};
    bus.wbs_sel_i = 4'hf;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    data = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Counts edges until job_valid is seen, bounded at 100.
  task automatic wait_valid(input int start, output int n);
    n = start;
    while (!bus.job_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pulse_ready();
    bus.job_ready = 1'b1;
    @(posedge clk); #1;
    bus.job_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.wbs_ack_o); end
    checks++; if (bus.wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.wbs_dat_o); end
    checks++; if (bus.job_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.job_valid); end
    checks++; if (bus.job_target !== 256'd0) begin errors++; $display("FAIL reset_target: got %h want 0", bus.job_target); end
    checks++; if (bus.job_header !== 608'd0) begin errors++; $display("FAIL reset_header: got nonzero want 0"); end
    checks++; if (bus.job_nonce_start !== 32'h0) begin errors++; $display("FAIL reset_nonce: got %h want 0", bus.job_nonce_start); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
    wb_read(5'd18, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_staging: got %h want 0", rd); end
  endtask

  task automatic test_decode_long();
    logic [31:0]  rd;
    logic [255:0] exp_tgt;
    int           n;
    exp_tgt = DEC_EN ? (256'hffff << 208) : {224'd0, 32'h1d00ffff};
    wb_write(5'd0, 32'hdeadbeef, 4'hf);
    wb_write(5'd18, 32'h1d00ffff, 4'hf);
    wb_write(5'd19, 32'h00001000, 4'hf);
    wb_write(5'd20, 32'h1, 4'hf);
    wait_valid(1, n);
    checks++; if (n !== (DEC_EN ? 27 : 1)) begin errors++; $display("FAIL long_latency: got %0d want %0d", n, DEC_EN ? 27 : 1); end
    checks++; if (bus.job_target !== exp_tgt) begin errors++; $display("FAIL long_target: got %h want %h", bus.job_target, exp_tgt); end
    checks++; if (bus.job_header[31:0] !== 32'hdeadbeef) begin errors++; $display("FAIL long_hdr0: got %h want deadbeef", bus.job_header[31:0]); end
    checks++; if (bus.job_header[607:576] !== 32'h1d00ffff) begin errors++; $display("FAIL long_hdr18: got %h want 1d00ffff", bus.job_header[607:576]); end
    checks++; if (bus.job_header[191:160] !== 32'h0) begin errors++; $display("FAIL long_hdr5: got %h want 0", bus.job_header[191:160]); end
    checks++; if (bus.job_nonce_start !== 32'h00001000) begin errors++; $display("FAIL long_nonce: got %h want 00001000", bus.job_nonce_start); end
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL long_status: got %h want 00000001", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0]  rd;
    logic [255:0] exp_tgt;
    exp_tgt = DEC_EN ? (256'hffff << 208) : {224'd0, 32'h1d00ffff};
    repeat (10) @(posedge clk);
    #1;
    wb_write(5'd0, 32'h55555555, 4'hf);
    wb_write(5'd20, 32'h1, 4'hf);
    checks++; if (bus.job_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", bus.job_valid); end
    checks++; if (bus.job_header[31:0] !== 32'hdeadbeef) begin errors++; $display("FAIL bp_hdr0: got %h want deadbeef", bus.job_header[31:0]); end
    checks++; if (bus.job_target !== exp_tgt) begin errors++; $display("FAIL bp_target: got %h want %h", bus.job_target, exp_tgt); end
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h00000009) begin errors++; $display("FAIL bp_status: got %h want 00000009", rd); end
    pulse_ready();
    checks++; if (bus.job_valid !== 1'b0) begin errors++; $display("FAIL bp_fall: got %b want 0", bus.job_valid); end
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h00000108) begin errors++; $display("FAIL bp_taken: got %h want 00000108", rd); end
    wb_write(5'd20, 32'h2, 4'hf);
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h00000100) begin errors++; $display("FAIL bp_clear: got %h want 00000100", rd); end
  endtask

  task automatic test_decode_short();
    logic [31:0]  rd;
    logic [255:0] exp_tgt;
    int           n;
    exp_tgt = DEC_EN ? 256'h80 : {224'd0, 32'h02008000};
    wb_write(5'd18, 32'h02008000, 4'hf);
    wb_write(5'd20, 32'h1, 4'hf);
    wait_valid(1, n);
    checks++; if (n !== (DEC_EN ? 2 : 1)) begin errors++; $display("FAIL short_latency: got %0d want %0d", n, DEC_EN ? 2 : 1); end
    checks++; if (bus.job_target !== exp_tgt) begin errors++; $display("FAIL short_target: got %h want %h", bus.job_target, exp_tgt); end
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h00000101) begin errors++; $display("FAIL short_status: got %h want 00000101", rd); end
    pulse_ready();
    checks++; if (bus.job_valid !== 1'b0) begin errors++; $display("FAIL short_fall: got %b want 0", bus.job_valid); end
  endtask

  task automatic test_target_err();
    logic [31:0]  rd;
    logic [255:0] exp_tgt;
    logic [31:0]  exp_st;
    int           n;
    exp_tgt = DEC_EN ? 256'd0 : {224'd0, 32'h1d800000};
    exp_st  = DEC_EN ? 32'h00000205 : 32'h00000201;
    wb_write(5'd18, 32'h1d800000, 4'hf);
    wb_write(5'd20, 32'h1, 4'hf);
    wait_valid(1, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL err_latency: got %0d want 1", n); end
    checks++; if (bus.job_target !== exp_tgt) begin errors++; $display("FAIL err_target: got %h want %h", bus.job_target, exp_tgt); end
    wb_read(5'd21, rd);
    checks++; if (rd !== exp_st) begin errors++; $display("FAIL err_status: got %h want %h", rd, exp_st); end
    pulse_ready();
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd;
    wb_write(5'd0, 32'h11223344, 4'hf);
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'hAABBCCDD;
    bus.wbs_sel_i = 4'b0011;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    checks++; if (bus.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL bl_ack_pre: got %b want 0", bus.wbs_ack_o); end
    @(posedge clk); #1;
    checks++; if (bus.wbs_ack_o !== 1'b1) begin errors++; $display("FAIL bl_ack_hi: got %b want 1", bus.wbs_ack_o); end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL bl_ack_lo: got %b want 0", bus.wbs_ack_o); end
    wb_read(5'd0, rd);
    checks++; if (rd !== 32'h1122CCDD) begin errors++; $display("FAIL bl_readback: got %h want 1122ccdd", rd); end
    wb_read(5'd20, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bl_ctrl_read: got %h want 0", rd); end
    wb_write(5'd25, 32'hffffffff, 4'hf);
    wb_read(5'd25, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bl_unmapped: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  rd;
    logic [255:0] exp_tgt;
    int           n;
    exp_tgt = DEC_EN ? 256'h123456 : {224'd0, 32'h03123456};
    wb_write(5'd18, 32'h03123456, 4'hf);
    wb_write(5'd20, 32'h1, 4'hf);
    wait_valid(1, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL b2b_latency_a: got %0d want 1", n); end
    checks++; if (bus.job_target !== exp_tgt) begin errors++; $display("FAIL b2b_target_a: got %h want %h", bus.job_target, exp_tgt); end
    wb_write(5'd18, 32'h04000001, 4'hf);
    bus.wbs_adr_i = {25'd0, 5'd20, 2'b00};
    bus.wbs_dat_i = 32'h1;
    bus.wbs_sel_i = 4'hf;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.job_ready = 1'b1;
    @(posedge clk); #1;
    bus.job_ready = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    checks++; if (bus.job_valid !== 1'b0) begin errors++; $display("FAIL b2b_fall: got %b want 0", bus.job_valid); end
    exp_tgt = DEC_EN ? 256'h100 : {224'd0, 32'h04000001};
    wait_valid(0, n);
    checks++; if (n !== (DEC_EN ? 2 : 1)) begin errors++; $display("FAIL b2b_latency_b: got %0d want %0d", n, DEC_EN ? 2 : 1); end
    checks++; if (bus.job_target !== exp_tgt) begin errors++; $display("FAIL b2b_target_b: got %h want %h", bus.job_target, exp_tgt); end
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h00000401) begin errors++; $display("FAIL b2b_status: got %h want 00000401", rd); end
  endtask

  task automatic test_commit_clear();
    logic [31:0] rd;
    wb_write(5'd20, 32'h3, 4'hf);
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h00000401) begin errors++; $display("FAIL cc_status: got %h want 00000401", rd); end
    checks++; if (bus.job_header[607:576] !== 32'h04000001) begin errors++; $display("FAIL cc_hdr18: got %h want 04000001", bus.job_header[607:576]); end
    pulse_ready();
    checks++; if (bus.job_valid !== 1'b0) begin errors++; $display("FAIL cc_fall: got %b want 0", bus.job_valid); end
  endtask

  task automatic test_reset_mid_decode();
    logic [31:0]  rd;
    logic [255:0] exp_tgt;
    int           n;
    wb_write(5'd18, 32'h20000001, 4'hf);
    wb_write(5'd20, 32'h1, 4'hf);
    wb_read(5'd21, rd);
    checks++; if (rd !== (DEC_EN ? 32'h00000502 : 32'h00000501)) begin errors++; $display("FAIL rmd_busy_status: got %h want %h", rd, DEC_EN ? 32'h00000502 : 32'h00000501); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (bus.job_valid !== 1'b0) begin errors++; $display("FAIL rmd_valid: got %b want 0", bus.job_valid); end
    checks++; if (bus.job_target !== 256'd0) begin errors++; $display("FAIL rmd_target: got %h want 0", bus.job_target); end
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmd_status: got %h want 0", rd); end
    exp_tgt = DEC_EN ? (256'h1 << 232) : {224'd0, 32'h20000001};
    wb_write(5'd18, 32'h20000001, 4'hf);
    wb_write(5'd19, 32'hcafef00d, 4'hf);
    wb_write(5'd20, 32'h1, 4'hf);
    wait_valid(1, n);
    checks++; if (n !== (DEC_EN ? 30 : 1)) begin errors++; $display("FAIL rmd_latency: got %0d want %0d", n, DEC_EN ? 30 : 1); end
    checks++; if (bus.job_target !== exp_tgt) begin errors++; $display("FAIL rmd_target_new: got %h want %h", bus.job_target, exp_tgt); end
    checks++; if (bus.job_nonce_start !== 32'hcafef00d) begin errors++; $display("FAIL rmd_nonce: got %h want cafef00d", bus.job_nonce_start); end
    wb_read(5'd21, rd);
    checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL rmd_status_new: got %h want 00000001", rd); end
    pulse_ready();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    bus.job_ready = 1'b0;
    test_reset();
    test_decode_long();
    test_backpressure();
    test_decode_short();
    test_target_err();
    test_byte_lane();
    test_back_to_back();
    test_commit_clear();
    test_reset_mid_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
